// File: rtl/lnvd_pkg.sv
// Shared constants, FSM encoding and channel-select helper for the LNVD
// acquisition scheduler.
package lnvd_pkg;

    localparam int LNVD_DATA_W      = 12;
    localparam int LNVD_N_CH        = 4;
    localparam int LNVD_DIV_DEFAULT = 200;
    localparam int LNVD_DIV_MIN     = 4;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    // Lowest set bit of a 4-bit channel mask; 0 when the mask is empty.
    function automatic logic [1:0] lowest_ch(input logic [3:0] m);
        lowest_ch = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (m[i]) lowest_ch = 2'(i);
        end
    endfunction

endpackage

// File: rtl/lnvd_rate_gen.sv
// Programmable decimation strobe: counts 0..D-1 while enabled, with
// D = max(div_cfg, 4) latched on enable rising and on each wrap.
module lnvd_rate_gen
    import lnvd_pkg::*;
#(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [DIV_W-1:0] div_cfg,
    output logic             strobe
);

    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] d_reg;
    logic [DIV_W-1:0] d_cfg;
    logic [DIV_W-1:0] d_cur;
    logic             en_q;

    assign d_cfg = (div_cfg < DIV_W'(LNVD_DIV_MIN)) ? DIV_W'(LNVD_DIV_MIN) : div_cfg;
    // On the first enabled cycle the live config applies so period D holds from the start.
    assign d_cur  = (en && !en_q) ? d_cfg : d_reg;
    assign strobe = en && (cnt == (d_cur - DIV_W'(1)));

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= '0;
            d_reg <= DIV_W'(LNVD_DIV_DEFAULT);
            en_q  <= 1'b0;
        end else begin
            en_q <= en;
            if (!en) begin
                cnt <= '0;
            end else if (strobe) begin
                cnt   <= '0;
                d_reg <= d_cfg;
            end else begin
                cnt <= cnt + DIV_W'(1);
                if (!en_q) d_reg <= d_cfg;
            end
        end
    end

endmodule

// File: rtl/lnvd_chan_sched.sv
// Snapshots four channels on each decimation strobe and serializes the
// enabled channels, ascending, onto one valid/ready link.
module lnvd_chan_sched
    import lnvd_pkg::*;
#(
    parameter int DATA_W = LNVD_DATA_W,
    parameter int DIV_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [DIV_W-1:0]  div_cfg,
    input  logic [3:0]        ch_en,
    input  logic [DATA_W-1:0] data_in1,
    input  logic [DATA_W-1:0] data_in2,
    input  logic [DATA_W-1:0] data_in3,
    input  logic [DATA_W-1:0] data_in4,
    input  logic              clr_ovr,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        out_ch,
    output logic              out_sof,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              sample_strobe,
    output logic              overrun,
    output logic              busy
);

    localparam int N_CH = LNVD_N_CH;

    state_t                        state, state_nxt;
    logic [N_CH-1:0][DATA_W-1:0]   snap;
    logic [N_CH-1:0]               mask;
    logic [N_CH-1:0]               rem;
    logic [1:0]                    cur_ch;
    logic [N_CH-1:0]               cur_bit;
    logic                          strobe, last, hs, slot_free, capture, drop;

    lnvd_rate_gen #(.DIV_W(DIV_W)) u_rate (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .div_cfg (div_cfg),
        .strobe  (strobe)
    );

    assign sample_strobe = strobe;

    // rem holds the channels of the current frame not yet handed off.
    assign cur_ch    = lowest_ch(rem);
    assign cur_bit   = N_CH'(1) << cur_ch;
    assign last      = (rem & ~cur_bit) == '0;
    assign hs        = (state == SEND) && out_ready;
    assign slot_free = (state == IDLE) || (hs && last);
    assign capture   = strobe && slot_free;
    assign drop      = strobe && !slot_free;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (capture && ch_en != '0) state_nxt = SEND;
            SEND: if (hs && last) state_nxt = (capture && ch_en != '0) ? SEND : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        out_valid = 1'b0;
        busy      = 1'b0;
        out_ch    = 2'd0;
        out_data  = '0;
        out_sof   = 1'b0;
        if (state == SEND) begin
            out_valid = 1'b1;
            busy      = 1'b1;
            out_ch    = cur_ch;
            out_data  = snap[cur_ch];
            out_sof   = (rem == mask);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            snap    <= '0;
            mask    <= '0;
            rem     <= '0;
            overrun <= 1'b0;
        end else begin
            if (capture) begin
                snap <= {data_in4, data_in3, data_in2, data_in1};
                mask <= ch_en;
                rem  <= ch_en;
            end else if (hs) begin
                rem <= rem & ~cur_bit;
            end
            if (drop)         overrun <= 1'b1;
            else if (clr_ovr) overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_lnvd_chan_sched.sv
// Scoreboard bench: a frame-level reference model pushes expected beats on
// each capture; a negedge monitor pops and compares them as the DUT emits.
module tb_lnvd_chan_sched;

    typedef struct {
        logic [11:0] data;
        logic [1:0]  ch;
        logic        sof;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst, en, clr_ovr, out_ready;
    logic [15:0] div_cfg;
    logic [3:0]  ch_en;
    logic [11:0] data_in1, data_in2, data_in3, data_in4;
    logic [11:0] out_data;
    logic [1:0]  out_ch;
    logic        out_sof, out_valid, sample_strobe, overrun, busy;

    int checks = 0;
    int errors = 0;

    beat_t exp_q[$];
    int    exp_strobe, exp_busy, exp_ovr, after_rst;
    bit    model_ready = 1'b0;

    always #5 clk = ~clk;

    lnvd_chan_sched dut (
        .clk           (clk),
        .rst           (rst),
        .en            (en),
        .div_cfg       (div_cfg),
        .ch_en         (ch_en),
        .data_in1      (data_in1),
        .data_in2      (data_in2),
        .data_in3      (data_in3),
        .data_in4      (data_in4),
        .clr_ovr       (clr_ovr),
        .out_data      (out_data),
        .out_ch        (out_ch),
        .out_sof       (out_sof),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .sample_strobe (sample_strobe),
        .overrun       (overrun),
        .busy          (busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, req);
        end
    endtask

    function automatic int clamp(input int d);
        return (d < 4) ? 4 : d;
    endfunction

    // Reference model: at posedge+2 apply the cycle that just ended (inputs
    // saved last time), then predict this cycle's strobe/busy/overrun.
    initial begin
        int cnt_m, d_m, pend, k;
        bit en_prev, ovr_m, stb, free, first;
        bit p_rst, p_en, p_ready, p_clr;
        int p_div;
        logic [3:0]  p_mask;
        logic [11:0] p_data[4];
        cnt_m = 0; d_m = 200; pend = 0; en_prev = 0; ovr_m = 0;
        p_rst = 1; p_en = 0; p_ready = 0; p_clr = 0; p_div = 200; p_mask = 0;
        foreach (p_data[i]) p_data[i] = '0;
        forever begin
            @(posedge clk);
            #2;
            after_rst = p_rst;
            if (p_rst) begin
                cnt_m = 0; d_m = 200; en_prev = 0; pend = 0; ovr_m = 0;
                exp_q.delete();
            end else begin
                first = p_en && !en_prev;
                if (first) d_m = clamp(p_div);
                stb  = p_en && (cnt_m == d_m - 1);
                free = (pend == 0) || (pend == 1 && p_ready);
                if (pend > 0 && p_ready) pend--;
                if (stb) begin
                    if (free) begin
                        k = 0;
                        for (int i = 0; i < 4; i++) begin
                            if (p_mask[i]) begin
                                exp_q.push_back('{data: p_data[i], ch: 2'(i), sof: (k == 0)});
                                k++;
                            end
                        end
                        pend = k;
                    end else begin
                        ovr_m = 1;
                    end
                end
                if (p_clr && !(stb && !free)) ovr_m = 0;
                if (!p_en) cnt_m = 0;
                else if (stb) begin cnt_m = 0; d_m = clamp(p_div); end
                else cnt_m++;
                en_prev = p_en;
            end
            exp_strobe = (en && (cnt_m == ((en && !en_prev) ? clamp(int'(div_cfg)) : d_m) - 1)) ? 1 : 0;
            exp_busy   = (pend > 0) ? 1 : 0;
            exp_ovr    = ovr_m;
            p_rst = rst; p_en = en; p_ready = out_ready; p_clr = clr_ovr;
            p_div = int'(div_cfg); p_mask = ch_en;
            p_data[0] = data_in1; p_data[1] = data_in2; p_data[2] = data_in3; p_data[3] = data_in4;
            model_ready = 1'b1;
        end
    end

    // Monitor.
    initial begin
        beat_t h;
        forever begin
            @(negedge clk);
            if (model_ready) begin
                chk("strobe", 32'(sample_strobe), 32'(exp_strobe));
                chk("overrun", 32'(overrun), 32'(exp_ovr));
                chk("busy", 32'(busy), 32'(exp_busy));
                chk("valid", 32'(out_valid), 32'(exp_busy));
                if (after_rst != 0) begin
                    chk("rst_data", 32'(out_data), 32'd0);
                    chk("rst_ch", 32'(out_ch), 32'd0);
                    chk("rst_sof", 32'(out_sof), 32'd0);
                end
                if (out_valid === 1'b1) begin
                    if (exp_q.size() == 0) begin
                        chk("beat_unexpected", 32'(out_valid), 32'd0);
                    end else begin
                        h = exp_q[0];
                        chk("beat_data", 32'(out_data), 32'(h.data));
                        chk("beat_ch", 32'(out_ch), 32'(h.ch));
                        chk("beat_sof", 32'(out_sof), 32'(h.sof));
                        if (out_ready === 1'b1) void'(exp_q.pop_front());
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_data();
        data_in1 = 12'($urandom); data_in2 = 12'($urandom);
        data_in3 = 12'($urandom); data_in4 = 12'($urandom);
    endtask

    initial begin
        rst = 1; en = 0; div_cfg = 16'd200; ch_en = 4'h0; clr_ovr = 0; out_ready = 0;
        data_in1 = 0; data_in2 = 0; data_in3 = 0; data_in4 = 0;
        repeat (3) tick();
        rst = 0;
        repeat (500) tick();

        // Nominal: 4 beats every 200 cycles.
        ch_en = 4'hF; out_ready = 1; en = 1;
        data_in1 = 12'h111; data_in2 = 12'h222; data_in3 = 12'h333; data_in4 = 12'h444;
        repeat (900) tick();

        // Sparse mask with periodic back-pressure.
        en = 0; tick();
        div_cfg = 16'd20; ch_en = 4'b1010; en = 1;
        for (int i = 0; i < 300; i++) begin
            out_ready = ((i / 3) % 2) == 0;
            rand_data();
            tick();
        end

        // Overrun: stall output, then clear alone, then clear during drops.
        en = 0; out_ready = 1; repeat (6) tick();
        div_cfg = 16'd4; ch_en = 4'hF; out_ready = 0; en = 1;
        repeat (20) tick();
        clr_ovr = 1; tick();
        clr_ovr = 0; repeat (3) tick();
        clr_ovr = 1; repeat (6) tick();
        clr_ovr = 0; out_ready = 1; repeat (20) tick();

        // Clamp to 4 with back-to-back frames, then reset mid-frame.
        en = 0; tick();
        div_cfg = 16'd1; ch_en = 4'hF; out_ready = 1; en = 1;
        for (int i = 0; i < 200; i++) begin
            rand_data();
            rst = (i == 101);
            tick();
        end
        rst = 0;

        // Randomized traffic.
        for (int i = 0; i < 4000; i++) begin
            rst       = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 49) == 0) en = ~en;
            if ($urandom_range(0, 99) == 0) div_cfg = 16'($urandom_range(0, 12));
            out_ready = ($urandom_range(0, 3) != 0);
            clr_ovr   = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 7) == 0) ch_en = 4'($urandom);
            rand_data();
            tick();
        end
        rst = 0; en = 0; out_ready = 1; clr_ovr = 0;
        repeat (20) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lnvd_chan_sched.md
# lnvd_chan_sched

Sample scheduler for the LNVD 4-channel 12-bit acquisition path. It generates the programmable decimation strobe on the 50 MHz clock and snapshots all four channels on each strobe. It then shares a single valid/ready output link between the four channels, emitting each captured frame as ascending-channel beats. It sits between the ADC channel registers and the downstream packetizer/transmit logic, and replaces free-running fixed-ratio downsampling with a configurable, back-pressure-aware sequencer.

## Interface
- DATA_W, 12, sample width per channel
- N_CH, 4, channel count (fixed at 4; ch index is 2 bits)
- DIV_W, 16, width of the period configuration
- Clock and reset: one clock; reset is synchronous and active-high.
- clk  in  1  50 MHz system clock; all logic on its rising edge
- rst  in  1  synchronous, active-high reset
- en  in  1  level; 1 = period counter runs
- div_cfg  in  DIV_W  sample period in clk cycles; below 4 is treated as 4
- ch_en  in  4  channel enable mask, bit i = channel i+1
- data_in1..data_in4  in  DATA_W each  live channel samples
- clr_ovr  in  1  pulse, clears overrun
- out_data  out  DATA_W  current beat sample
- out_ch  out  2  channel index 0..3 of current beat
- out_sof  out  1  high on first beat of a frame
- out_valid  out  1  beat valid
- out_ready  in  1  downstream accept
- sample_strobe  out  1  one-cycle pulse at each capture instant
- overrun  out  1  sticky; a frame was dropped
- busy  out  1  frame in flight (FSM not IDLE)

## Operation
- Period counter `cnt`: held at 0 while en=0. While en=1 it counts 0..D-1, then wraps to 0. D = max(div_cfg, 4), sampled when cnt reloads to 0 and on en rising.
- Strobe: sample_strobe=1 in the cycle cnt==D-1 with en=1. The first strobe falls on the D-th consecutive cycle en is high.
- Capture on strobe: if slot free, register data_in1..4 and ch_en into a snapshot. The slot is free when the FSM is IDLE, or when the last beat of the current frame handshakes in this same cycle.
- Slot busy at strobe: the snapshot is unchanged, the frame is dropped, overrun is set. The strobe still pulses.
- Snapshot mask == 0: no frame is emitted and the FSM stays IDLE; no overrun.
- FSM states:
  - IDLE -> SEND on accepted capture with nonzero mask.
  - SEND: presents the lowest enabled channel not yet sent.
  - On handshake (out_valid & out_ready): advance to the next enabled channel. After the last one, return to IDLE, or stay in SEND with the new frame if a capture is accepted that cycle.
- Beat contents: out_data, out_ch and out_sof are stable while out_valid & !out_ready. out_sof=1 only on the first enabled channel of a frame.
- en deasserted mid-frame: the counter clears; the in-flight frame completes normally.
- ch_en and data_in changes affect only the next capture.
- overrun: set on drop, cleared by clr_ovr. If both occur in the same cycle, set wins.
- Reset (any time, including mid-frame): the frame is aborted. Next cycle: cnt=0, FSM=IDLE, and all outputs 0 (out_data, out_ch, out_sof, out_valid, sample_strobe, overrun, busy).

## Timing
- Capture at cycle t -> out_valid=1 at t+1 with the first enabled channel.
- With out_ready held 1, beats are back-to-back: a frame of k enabled channels occupies t+1..t+k.
- After the last handshake with no new capture, out_valid=0 in the next cycle.
- A capture coinciding with the last handshake gives no bubble: the new frame's first beat appears the next cycle.
- busy equals out_valid (registered state, no combinational ready->valid path).
- Default throughput: div_cfg=200 gives a 250 kHz strobe, 4 beats per 200 cycles.

## Structure
- Shared package lnvd_pkg holds:
  - constants LNVD_DATA_W=12, LNVD_N_CH=4, LNVD_DIV_DEFAULT=200, LNVD_DIV_MIN=4
  - FSM state encoding (IDLE, SEND).
- Sub-module lnvd_rate_gen: period counter, clamp, strobe generation. Ports: clk, rst, en, div_cfg, strobe.
- Top module: snapshot registers, mask-walk priority selector, FSM, overrun logic.

## Test plan
- Reset/defaults: rst=1 then release, en=0 for 500 cycles -> all outputs 0, no strobe.
- Nominal: div_cfg=200, ch_en=4'b1111, out_ready=1, inputs 12'h111/222/333/444 -> strobe every 200 cycles. Beats ch0..3 carry 111/222/333/444 on t+1..t+4, out_sof only on ch0.
- Mask/backpressure: ch_en=4'b1010, out_ready toggled every 3 cycles -> only ch1, ch3 emitted. Data held stable while not ready; out_sof on ch1.
- Overrun: div_cfg=4, out_ready=0 for 20 cycles -> first frame held intact, overrun=1. clr_ovr pulse -> 0. Simultaneous clr_ovr with a drop -> stays 1.
- Clamp/back-to-back: div_cfg=1, ch_en=4'b1111, out_ready=1 -> strobe period 4, continuous out_valid, no overrun.
- Reset mid-frame: rst during beat ch2 -> next cycle out_valid=0 and busy=0. First new strobe D cycles after en is seen high again.
